queue_cmd_alu: RTL
==================

// Module: queue_cmd_alu
// PURPOSE
//  Command front-end and arithmetic unit sitting directly upstream of the 10-entry
//  8-bit operand queue. Accepts user commands over a valid/ready handshake, checks
//  them against a mirrored occupancy count, computes binary results from the
//  queue's first/second outputs, and drives the queue's apply/op/in with one-cycle
//  apply pulses. Illegal commands are blocked here so the queue's own valid flag
//  never drops.
// PARAMETERS
//  DEPTH  10  queue capacity mirrored by the occupancy counter (4-bit count)
//  W      8   operand/result width; the divider runs W iterations
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  cmd_valid  in   1  command request
//  cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid & cmd_ready
//  cmd_op     in   3  0 push, 1 pop, 2 add, 3 sub, 4 mul, 5 div, 6 mod, 7 clear-error
//  cmd_data   in   W  push operand (op 0 only)
//  q_first    in   W  queue head (operand a)
//  q_second   in   W  queue entry behind head (operand b)
//  q_apply    out  1  one-cycle apply pulse to queue
//  q_op       out  3  op code to queue, equal to the accepted cmd_op
//  q_in       out  W  push data or computed result to queue
//  busy       out  1  high in every state except IDLE
//  count      out  4  mirrored queue occupancy
//  err        out  1  sticky error flag
//  err_code   out  2  0 none, 1 overflow, 2 underflow, 3 divide by zero
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1; q_apply=0; q_op=0; q_in=0; busy=0; count=0;
//   err=0; err_code=0. Reset is applied while DIV is in progress -> DIV is aborted;
//   q_apply is forced to 0 immediately. All outputs are registered.
//  FSM: IDLE, ISSUE, DIV, SETTLE, ERR.
//  IDLE, on accept: latch op, data, a=q_first, b=q_second, then:
//   op7 -> err=0, err_code=0, stay IDLE (no queue action, cmd_ready stays 1).
//   op0 with count==DEPTH -> ERR, code 1. op1 with count==0 -> ERR, code 2.
//   op2..6 with count<2 -> ERR, code 2. op5/6 with b==0 -> ERR, code 3.
//   op5/6 otherwise -> DIV. All other ops -> ISSUE with q_in precomputed:
//   push: data; pop: 0; add: a+b; sub: a-b; mul: low W bits of a*b.
//   All arithmetic is mod 2^W, unsigned.
//  DIV: restoring unsigned division, one quotient bit per cycle, exactly W cycles.
//   After the last cycle -> ISSUE with q_in=a/b (op5) or a%b (op6).
//  ISSUE: q_apply=1 for exactly this cycle with q_op/q_in stable. count changes at
//   the end of this cycle: +1 for push, -1 for pop and op2..6. Next state is SETTLE.
//  SETTLE: one cycle in which the queue outputs update; then IDLE.
//  ERR: err=1, err_code set (an error that is already pending is overwritten by the
//   newest one); no q_apply; count unchanged; one cycle, then IDLE.
//  Latency: cmd_ready is low for 2 cycles after accepting push/pop/add/sub/mul,
//   W+2 cycles after accepting div/mod, and 1 cycle after an error.
//  q_op/q_in hold their last issued values while q_apply=0.
//  err does not block commands; only op7 or rst clears it.
//  cmd_valid is ignored while cmd_ready=0. No command is dropped silently:
//   every accepted command ends in ISSUE, ERR or clear.
// TESTING
//  push 5, push 3, add -> pulses q_in=5, 3, 8 (q_op 0,0,2); count ends at 1.
//  push 7, push 200, mul -> q_in=120; repeat with sub -> q_in=63.
//  push 100, push 7, div -> q_in=14 after cmd_ready low 10 cycles; mod -> q_in=2.
//  push 9, push 0, div -> err=1, err_code=3, no q_apply, count stays 2;
//   then op7 -> err=0, err_code=0.
//  10 pushes then an 11th -> err_code=1, count=10; after reset, pop -> err_code=2.
//  rst asserted during DIV cycle 4 -> q_apply never pulses, count=0,
//   cmd_ready=1 after rst is released.

Source files
------------

// File: rtl/queue_cmd_alu.sv
// queue_cmd_alu: command front-end and ALU for a DEPTH-entry W-bit operand queue.
// Checks commands against a mirrored occupancy count and issues one-cycle apply pulses.
module queue_cmd_alu #(
    parameter int DEPTH = 10,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    input  logic [W-1:0] q_first,
    input  logic [W-1:0] q_second,
    output logic         q_apply,
    output logic [2:0]   q_op,
    output logic [W-1:0] q_in,
    output logic         busy,
    output logic [3:0]   count,
    output logic         err,
    output logic [1:0]   err_code
);
    localparam int SW = $clog2(W);

    typedef enum logic [2:0] {IDLE, ISSUE, DIV, SETTLE, ERR} state_t;

    state_t         state, state_n;
    logic [2:0]     op_r;
    logic [W-1:0]   b_r, quo, rem, alu, quo_n, rem_n;
    logic [W:0]     rem_sh, diff;
    logic [SW-1:0]  step;
    logic [1:0]     code_n;
    logic           accept, is_div, ge, last;

    assign accept = cmd_valid & cmd_ready;
    assign is_div = cmd_op == 3'd5 || cmd_op == 3'd6;
    assign last   = step == SW'(W - 1);

    always_comb begin
        code_n = (cmd_op == 3'd0 && count == 4'(DEPTH)) ? 2'd1 :
                 (cmd_op == 3'd1 && count == 4'd0) ? 2'd2 :
                 (cmd_op >= 3'd2 && cmd_op <= 3'd6 && count < 4'd2) ? 2'd2 :
                 (is_div && q_second == '0) ? 2'd3 : 2'd0;
        alu = cmd_op == 3'd0 ? cmd_data :
              cmd_op == 3'd1 ? '0 :
              cmd_op == 3'd2 ? q_first + q_second :
              cmd_op == 3'd3 ? q_first - q_second : W'(q_first * q_second);
        // restoring division step: shift in next dividend bit, subtract if it fits
        rem_sh = {rem, quo[W-1]};
        diff   = rem_sh - {1'b0, b_r};
        ge     = !diff[W];
        rem_n  = ge ? diff[W-1:0] : rem_sh[W-1:0];
        quo_n  = {quo[W-2:0], ge};
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept && cmd_op != 3'd7)
                         state_n = code_n != 2'd0 ? ERR : is_div ? DIV : ISSUE;
            DIV:     if (last) state_n = ISSUE;
            ISSUE:   state_n = SETTLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            q_apply   <= 1'b0;
        end else begin
            state     <= state_n;
            cmd_ready <= state_n == IDLE;
            busy      <= state_n != IDLE;
            q_apply   <= state_n == ISSUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= '0;
            b_r      <= '0;
            quo      <= '0;
            rem      <= '0;
            step     <= '0;
            q_op     <= '0;
            q_in     <= '0;
            count    <= '0;
            err      <= 1'b0;
            err_code <= 2'd0;
        end else begin
            if (accept) begin
                op_r <= cmd_op;
                b_r  <= q_second;
                quo  <= q_first;
                rem  <= '0;
                step <= '0;
                if (cmd_op == 3'd7) begin
                    err      <= 1'b0;
                    err_code <= 2'd0;
                end else if (code_n != 2'd0) begin
                    err      <= 1'b1;
                    err_code <= code_n;
                end else if (!is_div) begin
                    q_op <= cmd_op;
                    q_in <= alu;
                end
            end
            if (state == DIV) begin
                rem  <= rem_n;
                quo  <= quo_n;
                step <= step + 1'b1;
                if (last) begin
                    q_op <= op_r;
                    q_in <= op_r == 3'd5 ? quo_n : rem_n;
                end
            end
            if (state == ISSUE)
                count <= op_r == 3'd0 ? count + 4'd1 : count - 4'd1;
        end
    end
endmodule
